match_job_arbiter: RTL and testbench

- Shares one needle/heystack string-matching pipeline between NUM_REQUESTERS byte-stream sources.
- Each job is STRING_SIZE needle bytes followed by heystack bytes ending in a last-flagged byte.
- Grants one requester per job, round-robin, and holds the grant until the job's heystack-last byte transfers.
- Sits between the host-side byte sources and the parser's in_data/in_valid/in_last inputs.

---
 rtl/string_matching_pkg.sv | 12 +
 rtl/round_robin_picker.sv | 33 +++
 rtl/match_job_arbiter.sv | 149 ++++++++++++++
 tb/tb_match_job_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/string_matching_pkg.sv
// Shared definitions for the string-matching front end.
package string_matching_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    STATE_IDLE     = 2'd0,
    STATE_NEEDLE   = 2'd1,
    STATE_HEYSTACK = 2'd2
  } state_t;

endpackage

// File: rtl/round_robin_picker.sv
// Combinational round-robin picker: the first set request searching upward
// from i_ptr+1, wrapping around.
module round_robin_picker #(
  parameter int unsigned NUM_REQUESTERS = 4
) (
  input  logic [NUM_REQUESTERS-1:0]         i_req,
  input  logic [$clog2(NUM_REQUESTERS)-1:0] i_ptr,
  output logic [$clog2(NUM_REQUESTERS)-1:0] o_winner,
  output logic                              o_any
);

  localparam int unsigned IW = $clog2(NUM_REQUESTERS);

  logic [IW-1:0] w_idx;
  logic          w_found;

  assign o_any = |i_req;

  // Scan all positions after the pointer; the first hit wins.
  always_comb begin
    o_winner = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int unsigned k = 1; k <= NUM_REQUESTERS; k++) begin
      w_idx = IW'((32'(i_ptr) + k) % NUM_REQUESTERS);
      if (!w_found && i_req[w_idx]) begin
        o_winner = w_idx;
        w_found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/match_job_arbiter.sv
// Job-level round-robin arbiter sharing one needle/heystack parser between
// several byte-stream requesters. The grant is held from arbitration until
// the heystack-last byte transfers; the datapath is a pure mux.
module match_job_arbiter
  import string_matching_pkg::*;
#(
  parameter int unsigned NUM_REQUESTERS = 4,
  parameter int unsigned STRING_SIZE    = 5
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic [NUM_REQUESTERS*BYTE_W-1:0]   req_data,
  input  logic [NUM_REQUESTERS-1:0]          req_valid,
  input  logic [NUM_REQUESTERS-1:0]          req_last,
  output logic [NUM_REQUESTERS-1:0]          req_ready,
  output logic [BYTE_W-1:0]                  out_data,
  output logic                               out_valid,
  output logic                               out_last,
  input  logic                               out_ready,
  output logic [$clog2(NUM_REQUESTERS)-1:0]  grant_id,
  output logic                               busy,
  output logic                               job_done,
  output logic [$clog2(NUM_REQUESTERS)-1:0]  job_done_id,
  output logic                               protocol_error
);

  localparam int unsigned IW = $clog2(NUM_REQUESTERS);
  localparam int unsigned CW = $clog2(STRING_SIZE + 1);
  localparam logic [CW-1:0] LAST_NEEDLE = CW'(STRING_SIZE - 1);

  state_t        r_state, w_state_nxt;
  logic [IW-1:0] r_grant, w_grant_nxt;
  logic [IW-1:0] r_rr_ptr, w_rr_nxt;
  logic [CW-1:0] r_needle_cnt, w_cnt_nxt;
  logic          r_job_done, w_job_done_nxt;
  logic [IW-1:0] r_job_done_id, w_done_id_nxt;
  logic          r_perr, w_perr_nxt;

  logic [IW-1:0]     w_winner;
  logic              w_any;
  logic [BYTE_W-1:0] w_sel_data;
  logic              w_sel_valid;
  logic              w_sel_last;
  logic              w_busy;
  logic              w_xfer;

  round_robin_picker #(
    .NUM_REQUESTERS(NUM_REQUESTERS)
  ) u_picker (
    .i_req    (req_valid),
    .i_ptr    (r_rr_ptr),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  // Select the granted requester's lane.
  always_comb begin
    w_sel_data  = '0;
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
      if (r_grant == IW'(i)) begin
        w_sel_data  = req_data[i*BYTE_W +: BYTE_W];
        w_sel_valid = req_valid[i];
        w_sel_last  = req_last[i];
      end
    end
  end

  // Outputs: gated to zero while idle; out_last only meaningful in heystack.
  always_comb begin
    w_busy    = (r_state != STATE_IDLE);
    out_data  = w_busy ? w_sel_data : '0;
    out_valid = w_busy & w_sel_valid;
    out_last  = (r_state == STATE_HEYSTACK) & w_sel_last;
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
      req_ready[i] = out_ready & w_busy & (r_grant == IW'(i));
    end
  end

  assign w_xfer         = out_valid & out_ready;
  assign busy           = w_busy;
  assign grant_id       = r_grant;
  assign job_done       = r_job_done;
  assign job_done_id    = r_job_done_id;
  assign protocol_error = r_perr;

  // Next-state: arbitrate in IDLE, count needle bytes, finish on heystack last.
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_rr_nxt       = r_rr_ptr;
    w_cnt_nxt      = r_needle_cnt;
    w_job_done_nxt = 1'b0;
    w_done_id_nxt  = r_job_done_id;
    w_perr_nxt     = r_perr;
    unique case (r_state)
      STATE_IDLE: begin
        if (w_any) begin
          w_grant_nxt = w_winner;
          w_rr_nxt    = w_winner;
          w_state_nxt = STATE_NEEDLE;
        end
      end
      STATE_NEEDLE: begin
        if (w_xfer) begin
          if (w_sel_last) w_perr_nxt = 1'b1;
          if (r_needle_cnt == LAST_NEEDLE) begin
            w_cnt_nxt   = '0;
            w_state_nxt = STATE_HEYSTACK;
          end else begin
            w_cnt_nxt = r_needle_cnt + 1'b1;
          end
        end
      end
      STATE_HEYSTACK: begin
        if (w_xfer && out_last) begin
          w_state_nxt    = STATE_IDLE;
          w_job_done_nxt = 1'b1;
          w_done_id_nxt  = r_grant;
        end
      end
      default: w_state_nxt = STATE_IDLE;
    endcase
  end

  // State and bookkeeping registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= STATE_IDLE;
      r_grant       <= '0;
      r_rr_ptr      <= IW'(NUM_REQUESTERS - 1);
      r_needle_cnt  <= '0;
      r_job_done    <= 1'b0;
      r_job_done_id <= '0;
      r_perr        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_rr_ptr      <= w_rr_nxt;
      r_needle_cnt  <= w_cnt_nxt;
      r_job_done    <= w_job_done_nxt;
      r_job_done_id <= w_done_id_nxt;
      r_perr        <= w_perr_nxt;
    end
  end

endmodule

// File: tb/tb_match_job_arbiter.sv
// Directed bench for match_job_arbiter: a 4-requester STRING_SIZE=5 instance
// and a 2-requester STRING_SIZE=1 instance.
module tb_match_job_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;

  logic [31:0] req_data = '0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic [7:0]  out_data;
  logic        out_valid, out_last;
  logic        out_ready = 1'b1;
  logic [1:0]  grant_id;
  logic        busy, job_done;
  logic [1:0]  job_done_id;
  logic        protocol_error;

  logic [15:0] req_data1 = '0;
  logic [1:0]  req_valid1 = '0;
  logic [1:0]  req_last1 = '0;
  logic [1:0]  req_ready1;
  logic [7:0]  out_data1;
  logic        out_valid1, out_last1;
  logic        out_ready1 = 1'b1;
  logic [0:0]  grant_id1;
  logic        busy1, job_done1;
  logic [0:0]  job_done_id1;
  logic        protocol_error1;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  match_job_arbiter #(.NUM_REQUESTERS(4), .STRING_SIZE(5)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_data(req_data), .req_valid(req_valid), .req_last(req_last), .req_ready(req_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .grant_id(grant_id), .busy(busy), .job_done(job_done), .job_done_id(job_done_id),
    .protocol_error(protocol_error)
  );

  match_job_arbiter #(.NUM_REQUESTERS(2), .STRING_SIZE(1)) dut1 (
    .clock(clock), .reset_n(reset_n),
    .req_data(req_data1), .req_valid(req_valid1), .req_last(req_last1), .req_ready(req_ready1),
    .out_data(out_data1), .out_valid(out_valid1), .out_last(out_last1), .out_ready(out_ready1),
    .grant_id(grant_id1), .busy(busy1), .job_done(job_done1), .job_done_id(job_done_id1),
    .protocol_error(protocol_error1)
  );

  task automatic set_lane(input int r, input logic [7:0] d, input logic l);
    req_data[r*8 +: 8] = d;
    req_last[r] = l;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; req_valid = '0; req_last = '0; req_data = '0; out_ready = 1'b1;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = '0; req_last = '0;
    #2;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b want=0", out_valid); end
    total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL rst_grant got=%0d want=0", grant_id); end
    total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL rst_req_ready got=%0b want=0", req_ready); end
    total++; if (job_done !== 1'b0) begin bad++; $display("FAIL rst_job_done got=%0b want=0", job_done); end
    total++; if (protocol_error !== 1'b0) begin bad++; $display("FAIL rst_perr got=%0b want=0", protocol_error); end
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL rst_busy1 got=%0b want=0", busy1); end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_single_job();
    string s;
    s = "helloxhellox";
    req_valid = 4'b0100; set_lane(2, s[0], 1'b0);
    #1;
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL sj_arb_bubble got v=%0b b=%0b want 0 0", out_valid, busy); end
    @(negedge clock);
    for (int k = 0; k < 12; k++) begin
      set_lane(2, s[k], k == 11);
      #1;
      total++; if (grant_id !== 2'd2) begin bad++; $display("FAIL sj_grant[%0d] got=%0d want=2", k, grant_id); end
      total++; if (out_valid !== 1'b1 || out_data !== s[k]) begin bad++; $display("FAIL sj_data[%0d] got=%0h/%0b want=%0h/1", k, out_data, out_valid, s[k]); end
      total++; if (out_last !== 1'(k == 11)) begin bad++; $display("FAIL sj_last[%0d] got=%0b want=%0b", k, out_last, k == 11); end
      total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL sj_ready[%0d] got=%0b want=0100", k, req_ready); end
      @(negedge clock);
    end
    req_valid = '0; req_last = '0;
    #1;
    total++; if (job_done !== 1'b1 || job_done_id !== 2'd2) begin bad++; $display("FAIL sj_done got=%0b id=%0d want 1 id 2", job_done, job_done_id); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL sj_busy_after got=%0b want=0", busy); end
    @(negedge clock);
    #1;
    total++; if (job_done !== 1'b0) begin bad++; $display("FAIL sj_done_pulse got=%0b want=0", job_done); end
  endtask

  task automatic test_round_robin();
    int pos[4];
    int exp_order[4];
    int started, finished, idle_run, cyc;
    logic prev_busy;
    logic [3:0] rdy;
    exp_order = '{0, 1, 3, 0};
    started = 0; finished = 0; idle_run = 0; cyc = 0; prev_busy = 1'b0;
    do_reset();
    for (int r = 0; r < 4; r++) pos[r] = 0;
    while (finished < 4 && cyc < 100) begin
      for (int r = 0; r < 4; r++) if (r != 2) set_lane(r, 8'(r * 16 + pos[r]), pos[r] == 5);
      req_valid = 4'b1011;
      #1;
      if (busy && !prev_busy && started < 4) begin
        total++; if (grant_id !== 2'(exp_order[started])) begin bad++; $display("FAIL rr_order[%0d] got=%0d want=%0d", started, grant_id, exp_order[started]); end
        if (started > 0) begin
          total++; if (idle_run != 1) begin bad++; $display("FAIL rr_idle_gap[%0d] got=%0d want=1", started, idle_run); end
        end
        started++; idle_run = 0;
      end
      if (busy && started > 0) begin
        total++;
        if (out_data !== 8'(exp_order[started-1] * 16 + pos[exp_order[started-1]])) begin
          bad++; $display("FAIL rr_data got=%0h want=%0h", out_data, 8'(exp_order[started-1] * 16 + pos[exp_order[started-1]]));
        end
      end
      if (!busy) idle_run++;
      rdy = req_ready; prev_busy = busy;
      @(negedge clock);
      for (int r = 0; r < 4; r++) begin
        if (rdy[r]) begin
          if (pos[r] == 5) begin pos[r] = 0; finished++; end
          else pos[r]++;
        end
      end
      cyc++;
    end
    req_valid = '0; req_last = '0;
    total++; if (finished != 4 || started != 4) begin bad++; $display("FAIL rr_timeout got=%0d/%0d jobs want=4/4", started, finished); end
  endtask

  task automatic test_backpressure();
    string s;
    logic rdy_pat[10];
    int pos, c;
    s = "abcdeZ";
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    pos = 0; c = 0;
    out_ready = 1'b1; req_valid = 4'b0010; set_lane(1, s[0], 1'b0);
    #1;
    @(negedge clock);
    while (pos < 6 && c < 10) begin
      out_ready = rdy_pat[c];
      set_lane(1, s[pos], pos == 5);
      #1;
      total++; if (out_valid !== 1'b1 || out_data !== s[pos]) begin bad++; $display("FAIL bp_data[%0d] got=%0h want=%0h", c, out_data, s[pos]); end
      total++; if (req_ready !== (rdy_pat[c] ? 4'b0010 : 4'b0000)) begin bad++; $display("FAIL bp_ready[%0d] got=%0b want=%0b", c, req_ready, rdy_pat[c] ? 4'b0010 : 4'b0000); end
      total++; if (out_last !== 1'(pos == 5)) begin bad++; $display("FAIL bp_last[%0d] got=%0b want=%0b", c, out_last, pos == 5); end
      if (pos < 5) begin
        total++; if (dut.r_needle_cnt !== 3'(pos)) begin bad++; $display("FAIL bp_needle_cnt[%0d] got=%0d want=%0d", c, dut.r_needle_cnt, pos); end
      end
      @(negedge clock);
      if (rdy_pat[c]) pos++;
      c++;
    end
    out_ready = 1'b1; req_valid = '0; req_last = '0;
    #1;
    total++; if (pos != 6 || c != 8) begin bad++; $display("FAIL bp_count got pos=%0d cyc=%0d want 6 8", pos, c); end
    total++; if (job_done !== 1'b1 || job_done_id !== 2'd1) begin bad++; $display("FAIL bp_done got=%0b id=%0d want 1 id 1", job_done, job_done_id); end
    @(negedge clock);
  endtask

  task automatic test_protocol_error();
    string s;
    s = "PQRSTyz";
    req_valid = 4'b1000; set_lane(3, s[0], 1'b0);
    #1;
    total++; if (protocol_error !== 1'b0) begin bad++; $display("FAIL pe_initial got=%0b want=0", protocol_error); end
    @(negedge clock);
    for (int p = 0; p < 7; p++) begin
      set_lane(3, s[p], p == 2 || p == 6);
      #1;
      total++; if (grant_id !== 2'd3) begin bad++; $display("FAIL pe_grant[%0d] got=%0d want=3", p, grant_id); end
      total++; if (out_last !== 1'(p == 6)) begin bad++; $display("FAIL pe_last[%0d] got=%0b want=%0b", p, out_last, p == 6); end
      total++; if (protocol_error !== 1'(p > 2)) begin bad++; $display("FAIL pe_sticky[%0d] got=%0b want=%0b", p, protocol_error, p > 2); end
      @(negedge clock);
    end
    req_valid = '0; req_last = '0;
    #1;
    total++; if (job_done !== 1'b1 || job_done_id !== 2'd3) begin bad++; $display("FAIL pe_done got=%0b id=%0d want 1 id 3", job_done, job_done_id); end
    total++; if (protocol_error !== 1'b1) begin bad++; $display("FAIL pe_hold got=%0b want=1", protocol_error); end
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b0100; set_lane(2, 8'h40, 1'b0);
    #1;
    @(negedge clock);
    for (int p = 0; p < 6; p++) begin
      set_lane(2, 8'(8'h40 + p), 1'b0);
      #1;
      @(negedge clock);
    end
    set_lane(2, 8'h46, 1'b0);
    #1;
    total++; if (busy !== 1'b1 || out_valid !== 1'b1) begin bad++; $display("FAIL rm_pre got b=%0b v=%0b want 1 1", busy, out_valid); end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00) begin bad++; $display("FAIL rm_async got b=%0b v=%0b d=%0h want 0 0 0", busy, out_valid, out_data); end
    total++; if (req_ready !== 4'b0 || grant_id !== 2'd0) begin bad++; $display("FAIL rm_ready_grant got=%0b/%0d want 0/0", req_ready, grant_id); end
    total++; if (protocol_error !== 1'b0 || job_done !== 1'b0) begin bad++; $display("FAIL rm_flags got pe=%0b jd=%0b want 0 0", protocol_error, job_done); end
    req_valid = '0; req_last = '0;
    @(negedge clock);
    reset_n = 1'b1;
    req_valid = 4'b0101;
    #1;
    total++; if (job_done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rm_no_done got jd=%0b b=%0b want 0 0", job_done, busy); end
    @(negedge clock);
    #1;
    total++; if (busy !== 1'b1 || grant_id !== 2'd0) begin bad++; $display("FAIL rm_next_grant got b=%0b g=%0d want 1 0", busy, grant_id); end
    do_reset();
  endtask

  task automatic test_string_size1();
    req_valid1 = 2'b10; req_data1[15:8] = "a"; req_last1 = 2'b00;
    #1;
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL s1_idle got=%0b want=0", busy1); end
    @(negedge clock);
    #1;
    total++; if (out_valid1 !== 1'b1 || out_last1 !== 1'b0 || grant_id1 !== 1'b1) begin bad++; $display("FAIL s1_needle got v=%0b l=%0b g=%0d want 1 0 1", out_valid1, out_last1, grant_id1); end
    @(negedge clock);
    req_last1 = 2'b10;
    #1;
    total++; if (out_last1 !== 1'b1 || out_data1 !== 8'h61) begin bad++; $display("FAIL s1_heystack got l=%0b d=%0h want 1 61", out_last1, out_data1); end
    @(negedge clock);
    req_valid1 = '0; req_last1 = '0;
    #1;
    total++; if (job_done1 !== 1'b1 || job_done_id1 !== 1'b1) begin bad++; $display("FAIL s1_done got=%0b id=%0d want 1 id 1", job_done1, job_done_id1); end
    @(negedge clock);
    #1;
    total++; if (job_done1 !== 1'b0) begin bad++; $display("FAIL s1_done_pulse got=%0b want=0", job_done1); end
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_round_robin();
    test_backpressure();
    test_protocol_error();
    test_reset_mid();
    test_string_size1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
